// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem request and a 1-entry output buffer.
// Optional IF_MISALIGN_EXC_EN flags misaligned PCs instead of fetching them.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        pipeline_stop,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic        if_misalign
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  issued_pc_q, issued_pc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_inst_q, out_inst_d;
  logic         issue;
  logic         buf_free;
  logic [31:0]  fetch_addr;
`ifdef IF_MISALIGN_EXC_EN
  logic         mis_hold_q, mis_hold_d;
  logic         out_mis_q, out_mis_d;
`endif

  assign fetch_addr = {pc_q[31:2], 2'b00};
  assign buf_free   = ~out_valid_q | ~pipeline_stop;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    issue       = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
    mis_hold_d  = mis_hold_q;
    out_mis_d   = out_mis_q;
`endif

    if (out_valid_q && !pipeline_stop) begin
      out_valid_d = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      out_mis_d   = 1'b0;
`endif
    end

    if (redirect_valid) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_pc;
`ifdef IF_MISALIGN_EXC_EN
      mis_hold_d  = 1'b0;
      out_mis_d   = 1'b0;
`endif
      // A response landing this very cycle retires the outstanding request.
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StWait:  state_d = imem_rvalid ? StIdle : StDrop;
        StDrop:  state_d = imem_rvalid ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (buf_free) begin
`ifdef IF_MISALIGN_EXC_EN
            if (pc_q[1:0] != 2'b00) begin
              if (!mis_hold_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_q;
                out_inst_d  = NOP_INST;
                out_mis_d   = 1'b1;
                mis_hold_d  = 1'b1;
              end
            end else begin
              issue = 1'b1;
            end
`else
            issue = 1'b1;
`endif
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            out_valid_d = 1'b1;
            out_pc_d    = issued_pc_q;
            out_inst_d  = imem_rdata;
            state_d     = StIdle;
          end
        end
        StDrop: begin
          if (imem_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (issue) begin
      issued_pc_d = fetch_addr;
      pc_d        = pc_q + 32'd4;
      state_d     = StWait;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      issued_pc_q <= 32'h0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_inst_q  <= NOP_INST;
`ifdef IF_MISALIGN_EXC_EN
      mis_hold_q  <= 1'b0;
      out_mis_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
`ifdef IF_MISALIGN_EXC_EN
      mis_hold_q  <= mis_hold_d;
      out_mis_q   <= out_mis_d;
`endif
    end
  end

  // Idle with an empty buffer would otherwise request while reset is held.
  assign imem_req  = issue & ~rst;
  assign imem_addr = imem_req ? fetch_addr : 32'h0;
  assign if_valid  = out_valid_q;
  assign if_pc     = out_pc_q;
  assign if_inst   = out_valid_q ? out_inst_q : NOP_INST;
`ifdef IF_MISALIGN_EXC_EN
  assign if_misalign = out_valid_q & out_mis_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; memory responses are driven by hand.
module tb_if_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        pipeline_stop = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_MISALIGN_EXC_EN
  logic        if_misalign;
`endif

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pipeline_stop  (pipeline_stop),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
`ifdef IF_MISALIGN_EXC_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, Nop);

    // Straight-line fetch with 1-cycle memory latency.
    rst = 1'b0; #1;
    chk("sl_req0", {31'h0, imem_req}, 32'h1);
    chk("sl_addr0", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = inst_of(32'h0); #1;
    chk("sl_noreq_wait", {31'h0, imem_req}, 32'h0);
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("sl_valid0", {31'h0, if_valid}, 32'h1);
    chk("sl_pc0", if_pc, 32'h0);
    chk("sl_inst0", if_inst, inst_of(32'h0));
    chk("sl_addr4", imem_addr, 32'h4);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = inst_of(32'h4); #1;
    chk("sl_consumed", {31'h0, if_valid}, 32'h0);
    cyc();
    imem_rvalid = 1'b0;

    // Stall while holding the 0x4 entry.
    pipeline_stop = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_valid", {31'h0, if_valid}, 32'h1);
      chk("st_pc", if_pc, 32'h4);
      chk("st_inst", if_inst, inst_of(32'h4));
      chk("st_noreq", {31'h0, imem_req}, 32'h0);
      cyc();
    end
    pipeline_stop = 1'b0; #1;
    chk("st_resume_req", {31'h0, imem_req}, 32'h1);
    chk("st_resume_addr", imem_addr, 32'h8);
    cyc();

    // Redirect while waiting on 0x8: its data must be dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("rw_noreq", {31'h0, imem_req}, 32'h0);
    cyc();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = inst_of(32'h8); #1;
    chk("rw_drop_noreq", {31'h0, imem_req}, 32'h0);
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("rw_dropped", {31'h0, if_valid}, 32'h0);
    chk("rw_req", {31'h0, imem_req}, 32'h1);
    chk("rw_addr", imem_addr, 32'h100);
    cyc();

    // Redirect coincident with the response.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    imem_rvalid = 1'b1; imem_rdata = inst_of(32'h100); #1;
    chk("rr_noreq", {31'h0, imem_req}, 32'h0);
    cyc();
    redirect_valid = 1'b0; imem_rvalid = 1'b0; #1;
    chk("rr_dropped", {31'h0, if_valid}, 32'h0);
    chk("rr_addr", imem_addr, 32'h200);
    chk("rr_req", {31'h0, imem_req}, 32'h1);
    cyc();

    // Reset in WAIT, then a stale response after release.
    rst = 1'b1; #1;
    chk("rm_req", {31'h0, imem_req}, 32'h0);
    chk("rm_addr", imem_addr, 32'h0);
    chk("rm_inst", if_inst, Nop);
    cyc();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = inst_of(32'h200); #1;
    chk("rm_req_after", {31'h0, imem_req}, 32'h1);
    chk("rm_addr_after", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("rm_stale_ignored", {31'h0, if_valid}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = inst_of(32'h0);
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("rm_valid", {31'h0, if_valid}, 32'h1);
    chk("rm_pc", if_pc, 32'h0);
    chk("rm_inst_ok", if_inst, inst_of(32'h0));

    // Redirect coincident with a stall still flushes the buffer.
    pipeline_stop = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    chk("rs_noreq", {31'h0, imem_req}, 32'h0);
    cyc();
    redirect_valid = 1'b0; #1;
    chk("rs_flushed", {31'h0, if_valid}, 32'h0);
    chk("rs_inst", if_inst, Nop);
    chk("rs_req", {31'h0, imem_req}, 32'h1);
    chk("rs_addr", imem_addr, 32'h300);
    cyc();

    // PC wrap from the top of the address space.
    pipeline_stop = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("wr_pc", if_pc, 32'hFFFF_FFFC);
    chk("wr_inst", if_inst, 32'h1234_5678);
    chk("wr_addr_wrap", imem_addr, 32'h0);

    // Redirect to a misaligned target.
    redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    chk("ma_redir_noreq", {31'h0, imem_req}, 32'h0);
    cyc();
    redirect_valid = 1'b0; #1;
`ifdef IF_MISALIGN_EXC_EN
    chk("ma_noreq", {31'h0, imem_req}, 32'h0);
    cyc();
    chk("ma_valid", {31'h0, if_valid}, 32'h1);
    chk("ma_pc", if_pc, 32'h102);
    chk("ma_inst", if_inst, Nop);
    chk("ma_flag", {31'h0, if_misalign}, 32'h1);
    chk("ma_noreq2", {31'h0, imem_req}, 32'h0);
    cyc();
    chk("ma_hold_valid", {31'h0, if_valid}, 32'h0);
    chk("ma_hold_noreq", {31'h0, imem_req}, 32'h0);
    chk("ma_flag_clr", {31'h0, if_misalign}, 32'h0);
`else
    chk("al_req", {31'h0, imem_req}, 32'h1);
    chk("al_addr", imem_addr, 32'h100);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = inst_of(32'h100);
    cyc();
    imem_rvalid = 1'b0; #1;
    chk("al_valid", {31'h0, if_valid}, 32'h1);
    chk("al_pc", if_pc, 32'h100);
    chk("al_inst", if_inst, inst_of(32'h100));
    chk("al_next_addr", imem_addr, 32'h104);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the instruction presented when the output is invalid.
REQ-003 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  is the asynchronous, active-high reset.
REQ-005 redirect_valid  input  1  requests a PC redirect (branch, jump or exception).
REQ-006 redirect_pc  input  32  is the redirect target.
REQ-007 pipeline_stop  input  1  is the downstream stall; the output entry is held while it is high.
REQ-008 imem_req  output  1  is the one-cycle fetch request pulse.
REQ-009 imem_addr  output  32  is the fetch address, valid while imem_req=1.
REQ-010 imem_rvalid  input  1  is the response strobe, arriving at least 1 cycle after imem_req.
REQ-011 imem_rdata  input  32  is the instruction, valid with imem_rvalid.
REQ-012 if_valid  output  1  marks if_pc/if_inst as a real fetched instruction.
REQ-013 if_pc  output  32  is the PC of the presented instruction; it feeds the IF/ID register.
REQ-014 if_inst  output  32  is the presented instruction; it equals NOP_INST when if_valid=0.

Function
REQ-015 The block SHALL allow at most one outstanding request, with a 1-entry registered output buffer (out_valid, out_pc, out_inst).
REQ-016 The state machine SHALL have three states:
- IDLE: no request outstanding.
- WAIT: request outstanding.
- DROP: request outstanding whose response is discarded.
REQ-017 The block SHALL issue a request in IDLE when redirect_valid=0 and the buffer is empty or being consumed (pipeline_stop=0).
- On issue: imem_addr = pc, pc <= pc+4 (modulo 2^32), next state WAIT.
REQ-018 In WAIT, imem_rvalid with no redirect SHALL load the buffer with {1, issued pc, imem_rdata} and go to IDLE.
- The output appears the cycle after rvalid, giving a fetch-to-output latency of memory latency + 1.
REQ-019 The buffer SHALL be consumed on any cycle with out_valid=1 and pipeline_stop=0; otherwise it holds unchanged.
REQ-020 redirect_valid SHALL have top priority in every state.
- Clear out_valid and set pc <= redirect_pc.
- Issue no request that cycle.
REQ-021 Redirect in WAIT without rvalid that same cycle SHALL go to DROP.
- Redirect in WAIT with rvalid that same cycle SHALL discard the data and go to IDLE.
REQ-022 In DROP, imem_rvalid SHALL be discarded and the state goes to IDLE; a further redirect in DROP updates pc and stays in DROP.
REQ-023 A redirect coincident with pipeline_stop SHALL still clear the buffer.
REQ-024 imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-025 While rst=1 the block SHALL hold these values:
- state IDLE, pc = RESET_PC, out_valid = 0, out_pc = 0, out_inst = NOP_INST.
- imem_req = 0, imem_addr = 0, if_valid = 0, if_pc = 0, if_inst = NOP_INST.
REQ-026 Reset asserted mid-request SHALL abandon the request; a stale imem_rvalid after reset release is ignored because the state is IDLE.

Configuration
REQ-027 With macro IF_MISALIGN_EXC_EN defined, the block SHALL add output if_misalign (1 bit).
- A pc with pc[1:0] != 0 in IDLE issues no memory request.
- Instead it loads the buffer with {1, pc, NOP_INST}, sets if_misalign=1 alongside it, then waits for a redirect.
REQ-028 Without IF_MISALIGN_EXC_EN, the block SHALL have no if_misalign port and SHALL fetch at pc with bits [1:0] forced to 0.

Structure
REQ-029 The shared package SHALL hold:
- the state enum (IDLE/WAIT/DROP)
- the NOP_INST constant
- the default RESET_PC.
REQ-030 The block SHALL be a single module; no sub-module.

Verification
REQ-031 Straight-line fetch: reset release, 1-cycle memory latency, pipeline_stop=0 -> imem_addr 0x0, 0x4, 0x8 every 2 cycles, with if_pc following with matching imem_rdata.
REQ-032 Stall: pipeline_stop=1 for 3 cycles while out_valid=1 with if_pc=0x4 -> if_pc/if_inst held, no new imem_req; fetch resumes at 0x8 after release.
REQ-033 Redirect in WAIT: redirect_pc=0x100 one cycle after request to 0x8 -> rdata for 0x8 discarded (if_valid stays 0); next imem_addr is 0x100.
REQ-034 Redirect coincident with rvalid: rdata discarded, state IDLE; next cycle imem_addr = redirect_pc.
REQ-035 Reset mid-WAIT, then rvalid pulse after release -> ignored; first request is to RESET_PC.
REQ-036 With IF_MISALIGN_EXC_EN: redirect_pc=0x102 -> no imem_req; if_valid=1, if_pc=0x102, if_inst=NOP_INST, if_misalign=1.
